// File: rtl/mux2x1_rr_arbiter_pkg.sv
// Shared widths, depths and arbiter state encoding for the two-lane
// round-robin byte arbiter.
package mux_pkg;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int PTR_W  = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SERVE0 = 2'b01,
    SERVE1 = 2'b10
  } state_t;

endpackage

// File: rtl/mux2x1_rr_arbiter_fifo.sv
// Small synchronous FIFO used to buffer one requester lane.
// Read data is the head entry; a push to an empty FIFO is poppable one cycle later.
module fifo_sync
  import mux_pkg::*;
#(
  parameter int W = DATA_W,
  parameter int D = DEPTH,
  parameter int P = PTR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic [P:0]   count
);

  logic [W-1:0] mem [D];
  logic [P-1:0] wr_ptr;
  logic [P-1:0] rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Full and empty come from the pre-edge count, so a push while full is
  // dropped even if the same edge also pops.
  assign full    = (count == (P+1)'(D));
  assign do_push = push & ~full;
  assign do_pop  = pop & (count != '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + P'(1);
      if (do_pop)  rd_ptr <= rd_ptr + P'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (P+1)'(1);
        2'b01:   count <= count - (P+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mux2x1_rr_arbiter.sv
// Two-lane round-robin arbiter sharing one registered byte output with
// back-pressure; each lane is buffered in its own FIFO.
module mux2x1_rr_arbiter
  import mux_pkg::*;
(
  input  logic              clk,
  input  logic              Reset_L,
  input  logic [DATA_W-1:0] In0,
  input  logic              valid0,
  input  logic [DATA_W-1:0] In1,
  input  logic              valid1,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              outValid,
  output logic              grant_src,
  output logic              full0,
  output logic              full1,
  output logic              ovf0,
  output logic              ovf1
);

  state_t            state, state_nxt;
  logic              last_grant, last_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              valid_nxt;
  logic              gsrc_nxt;
  logic              pop0, pop1;
  logic              pick, take, slot_free;
  logic [DATA_W-1:0] dout0, dout1;
  logic [PTR_W:0]    level0, level1;

  fifo_sync u_fifo0 (
    .clk   (clk),
    .rst_n (Reset_L),
    .push  (valid0),
    .pop   (pop0),
    .din   (In0),
    .dout  (dout0),
    .full  (full0),
    .count (level0)
  );

  fifo_sync u_fifo1 (
    .clk   (clk),
    .rst_n (Reset_L),
    .push  (valid1),
    .pop   (pop1),
    .din   (In1),
    .dout  (dout1),
    .full  (full1),
    .count (level1)
  );

  always_comb begin
    state_nxt = state;
    data_nxt  = data_out;
    valid_nxt = outValid;
    gsrc_nxt  = grant_src;
    last_nxt  = last_grant;
    pop0      = 1'b0;
    pop1      = 1'b0;
    pick      = 1'b0;
    take      = 1'b0;
    slot_free = ~outValid | out_ready;

    if (slot_free) begin
      if ((level0 != '0) && (level1 != '0)) begin
        take = 1'b1;
        pick = ~last_grant;
      end else if (level0 != '0) begin
        take = 1'b1;
        pick = 1'b0;
      end else if (level1 != '0) begin
        take = 1'b1;
        pick = 1'b1;
      end

      if (take) begin
        pop0      = ~pick;
        pop1      = pick;
        data_nxt  = pick ? dout1 : dout0;
        valid_nxt = 1'b1;
        gsrc_nxt  = pick;
        last_nxt  = pick;
        state_nxt = pick ? SERVE1 : SERVE0;
      end else begin
        valid_nxt = 1'b0;
        state_nxt = IDLE;
      end
    end
  end

  // last_grant resets to lane 1 so that the first contended grant goes to lane 0.
  always_ff @(posedge clk or negedge Reset_L) begin
    if (!Reset_L) begin
      state      <= IDLE;
      data_out   <= '0;
      outValid   <= 1'b0;
      grant_src  <= 1'b0;
      last_grant <= 1'b1;
      ovf0       <= 1'b0;
      ovf1       <= 1'b0;
    end else begin
      state      <= state_nxt;
      data_out   <= data_nxt;
      outValid   <= valid_nxt;
      grant_src  <= gsrc_nxt;
      last_grant <= last_nxt;
      ovf0       <= ovf0 | (valid0 & full0);
      ovf1       <= ovf1 | (valid1 & full1);
    end
  end

endmodule

// File: tb/tb_mux2x1_rr_arbiter.sv
// Directed and randomized bench for mux2x1_rr_arbiter against a queue-based
// reference model of the two-lane round-robin behaviour.
module tb_mux2x1_rr_arbiter;
  import mux_pkg::*;

  logic              clk = 1'b0;
  logic              Reset_L = 1'b0;
  logic [DATA_W-1:0] In0 = '0, In1 = '0;
  logic              valid0 = 1'b0, valid1 = 1'b0, out_ready = 1'b0;
  logic [DATA_W-1:0] data_out;
  logic              outValid, grant_src, full0, full1, ovf0, ovf1;

  int checks = 0;
  int errors = 0;

  logic [7:0] q0[$], q1[$];
  logic       m_valid, m_gsrc, m_last, m_ovf0, m_ovf1;
  logic [7:0] m_data;

  logic [7:0] got[$];
  logic       gotg[$];
  logic       s_ov = 1'b0;
  logic [7:0] s_do = '0;
  logic       s_gs = 1'b0;

  mux2x1_rr_arbiter dut (
    .clk       (clk),
    .Reset_L   (Reset_L),
    .In0       (In0),
    .valid0    (valid0),
    .In1       (In1),
    .valid1    (valid1),
    .out_ready (out_ready),
    .data_out  (data_out),
    .outValid  (outValid),
    .grant_src (grant_src),
    .full0     (full0),
    .full1     (full1),
    .ovf0      (ovf0),
    .ovf1      (ovf1)
  );

  always #40 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    q0.delete();
    q1.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_gsrc  = 1'b0;
    m_last  = 1'b1;
    m_ovf0  = 1'b0;
    m_ovf1  = 1'b0;
  endfunction

  // One clock edge of the reference: pop decisions and full tests use the
  // queue sizes from before the edge.
  function automatic void model_edge();
    int s0, s1, lane;
    if (!Reset_L) begin
      model_reset();
      return;
    end
    s0   = q0.size();
    s1   = q1.size();
    lane = -1;
    if (!m_valid || out_ready) begin
      if (s0 > 0 && s1 > 0) lane = m_last ? 0 : 1;
      else if (s0 > 0)      lane = 0;
      else if (s1 > 0)      lane = 1;
      if (lane == 0)      m_data = q0.pop_front();
      else if (lane == 1) m_data = q1.pop_front();
      if (lane >= 0) begin
        m_valid = 1'b1;
        m_gsrc  = (lane == 1);
        m_last  = (lane == 1);
      end else begin
        m_valid = 1'b0;
      end
    end
    if (valid0) begin
      if (s0 == DEPTH) m_ovf0 = 1'b1;
      else             q0.push_back(In0);
    end
    if (valid1) begin
      if (s1 == DEPTH) m_ovf1 = 1'b1;
      else             q1.push_back(In1);
    end
  endfunction

  task automatic compare_all();
    chk("out_valid", outValid, m_valid);
    if (m_valid) begin
      chk("data_out", data_out, m_data);
      chk("grant_src", grant_src, m_gsrc);
    end
    chk("full0", full0, q0.size() == DEPTH);
    chk("full1", full1, q1.size() == DEPTH);
    chk("ovf0", ovf0, m_ovf0);
    chk("ovf1", ovf1, m_ovf1);
  endtask

  task automatic drive(input logic v0, input logic [7:0] d0,
                       input logic v1, input logic [7:0] d1, input logic rdy);
    valid0    = v0;
    In0       = d0;
    valid1    = v1;
    In1       = d1;
    out_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    if (Reset_L && s_ov && out_ready) begin
      got.push_back(s_do);
      gotg.push_back(s_gs);
    end
    model_edge();
    #1;
    compare_all();
    s_ov = outValid;
    s_do = data_out;
    s_gs = grant_src;
  endtask

  task automatic async_reset_check();
    #20;
    Reset_L = 1'b0;
    #1;
    model_reset();
    s_ov = 1'b0;
    chk("rst_out_valid", outValid, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_full0", full0, 0);
    chk("rst_full1", full1, 0);
    chk("rst_ovf0", ovf0, 0);
    chk("rst_ovf1", ovf1, 0);
    drive(0, 8'h00, 0, 8'h00, 1);
    tick();
    Reset_L = 1'b1;
    drive(1, 8'hA5, 1, 8'h5A, 1);
    tick();
    drive(0, 8'h00, 0, 8'h00, 1);
    tick();
    chk("first_grant_valid", outValid, 1);
    chk("first_grant_lane", grant_src, 0);
    chk("first_grant_data", data_out, 8'hA5);
  endtask

  initial begin
    model_reset();
    repeat (2) tick();
    chk("reset_valid", outValid, 0);
    chk("reset_grant", grant_src, 0);
    chk("reset_data", data_out, 0);
    Reset_L = 1'b1;

    // Alternation between two busy lanes
    got.delete(); gotg.delete();
    for (int i = 0; i < 4; i++) begin
      drive(1, 8'(i), 1, 8'(3 + i), 1);
      tick();
    end
    drive(0, 8'h00, 0, 8'h00, 1);
    repeat (10) tick();
    begin
      logic [7:0] exp_alt [8];
      exp_alt = '{8'h00, 8'h03, 8'h01, 8'h04, 8'h02, 8'h05, 8'h03, 8'h06};
      chk("alt_count", got.size(), 8);
      for (int i = 0; i < 8 && i < got.size(); i++) begin
        chk("alt_data", got[i], exp_alt[i]);
        chk("alt_grant", gotg[i], 32'(i % 2));
      end
    end

    // Single lane streaming, then idle
    got.delete(); gotg.delete();
    for (int i = 0; i < 4; i++) begin
      drive(0, 8'h00, 1, 8'(8'h10 + i), 1);
      tick();
    end
    drive(0, 8'h00, 0, 8'h00, 1);
    tick();
    tick();
    chk("single_idle_valid", outValid, 0);
    chk("single_idle_state", 32'(dut.state), 32'(IDLE));
    repeat (2) tick();
    chk("single_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      chk("single_data", got[i], 32'(8'h10 + i));
      chk("single_grant", gotg[i], 1);
    end

    // Back-pressure, fill to full and overflow
    got.delete(); gotg.delete();
    for (int i = 0; i < 6; i++) begin
      drive(1, 8'(8'h20 + i), 0, 8'h00, 0);
      tick();
    end
    chk("bp_full0", full0, 1);
    chk("bp_ovf0", ovf0, 1);
    chk("bp_held_data", data_out, 8'h20);
    chk("bp_held_valid", outValid, 1);
    drive(0, 8'h00, 0, 8'h00, 1);
    repeat (8) tick();
    chk("bp_drain_count", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++)
      chk("bp_drain_data", got[i], 32'(8'h20 + i));

    // Steady two-entry occupancy across pointer wrap
    got.delete(); gotg.delete();
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'(8'h30 + i), 0, 8'h00, 0);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1, 8'(8'h33 + i), 0, 8'h00, 1);
      tick();
      chk("wrap_level", dut.level0, 2);
    end
    drive(0, 8'h00, 0, 8'h00, 1);
    repeat (6) tick();
    chk("wrap_out_count", got.size(), 13);
    for (int i = 0; i < 13 && i < got.size(); i++)
      chk("wrap_data", got[i], 32'(8'h30 + i));

    // Randomized traffic with a mid-stream asynchronous reset
    for (int i = 0; i < 400; i++) begin
      if (i == 200) async_reset_check();
      drive(1'($urandom_range(0, 1)), 8'($urandom),
            1'($urandom_range(0, 1)), 8'($urandom),
            (i % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
      tick();
    end
    drive(0, 8'h00, 0, 8'h00, 1);
    repeat (12) tick();
    chk("final_drained", outValid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
